// File: rtl/eth_payload_serializer_if.sv
// Producer/framer bundle for the payload serializer: byte push side plus dibit output side.
// The master modport is the outside world; the slave modport is the serializer itself.
interface eth_payload_serializer_if #(
  parameter int DEPTH = 16
);
  logic                     flush;
  logic                     axiiv;
  logic [7:0]               axiid;
  logic                     axiir;
  logic                     stall;
  logic                     axiov;
  logic [1:0]               axiod;
  logic [$clog2(DEPTH):0]   level;
  logic [15:0]              underflow_count;

  modport master (
    output flush, axiiv, axiid, stall,
    input  axiir, axiov, axiod, level, underflow_count
  );

  modport slave (
    input  flush, axiiv, axiid, stall,
    output axiir, axiov, axiod, level, underflow_count
  );
endinterface

// File: rtl/eth_payload_serializer.sv
// Byte FIFO feeding an RMII framer one dibit per unstalled cycle, LS dibit first; fill dibits on starvation.
// Latency: byte pushed at edge N is presented from edge N+1; axiir is !full from registered pointers.
module eth_payload_serializer #(
  parameter int         DEPTH      = 16,
  parameter logic [1:0] FILL_DIBIT = 2'b00
) (
  input  logic                   clk,
  input  logic                   rst,
  eth_payload_serializer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]  r_mem [DEPTH];
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  logic [1:0]  r_idx;
  logic [15:0] r_underflow_count;

  logic        w_full;
  logic        w_empty;
  logic        w_push;
  logic        w_consume;
  logic        w_pop;
  logic        w_starve;
  logic [7:0]  w_head;

  assign w_full    = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_push    = bus.axiiv && !w_full && !bus.flush;
  assign w_consume = !bus.stall && !bus.flush;
  assign w_pop     = w_consume && !w_empty && (r_idx == 2'd3);
  assign w_starve  = w_consume && w_empty;
  assign w_head    = r_mem[r_rd_ptr[AW-1:0]];

  // Outputs depend only on registered state so the framer sees a stable dibit all cycle.
  assign bus.axiir           = !w_full;
  assign bus.axiov           = !w_empty;
  assign bus.axiod           = w_empty ? FILL_DIBIT : w_head[{r_idx, 1'b0} +: 2];
  assign bus.level           = r_wr_ptr - r_rd_ptr;
  assign bus.underflow_count = r_underflow_count;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= bus.axiid;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr          <= '0;
      r_rd_ptr          <= '0;
      r_idx             <= 2'd0;
      r_underflow_count <= 16'd0;
    end else begin
      if (bus.flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_idx    <= 2'd0;
      end else begin
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + 1'b1;
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + 1'b1;
        end
        // idx wraps 3 -> 0 naturally on the same edge that pops the head byte.
        if (w_consume && !w_empty) begin
          r_idx <= r_idx + 2'd1;
        end
      end
      if (w_starve && (r_underflow_count != 16'hFFFF)) begin
        r_underflow_count <= r_underflow_count + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_eth_payload_serializer.sv
// Directed bench for eth_payload_serializer: inputs driven and outputs sampled 1ns after each rising edge.
module tb_eth_payload_serializer;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  eth_payload_serializer_if #(.DEPTH(16)) bus ();

  eth_payload_serializer #(.DEPTH(16), .FILL_DIBIT(2'b00)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    bus.axiiv = 1'b1;
    bus.axiid = b;
    tick();
    bus.axiiv = 1'b0;
  endtask

  // Consume one byte's four dibits (stall must be low) and compare the reassembled byte.
  task automatic read_byte(input string tag, input logic [7:0] exp);
    logic [7:0] got;
    got = 8'h00;
    for (int d = 0; d < 4; d++) begin
      if (bus.axiov !== 1'b1) got = 8'hxx;
      got[2*d +: 2] = bus.axiod;
      tick();
    end
    check(tag, {8'h00, got}, {8'h00, exp});
  endtask

  logic [7:0] bytes5 [5];
  logic [1:0] seq8 [8];

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst       = 1'b0;
    bus.flush = 1'b0;
    bus.axiiv = 1'b0;
    bus.axiid = 8'h00;
    bus.stall = 1'b1;
    #12;
    check("rst_axiir", {15'd0, bus.axiir}, 16'd1);
    check("rst_axiov", {15'd0, bus.axiov}, 16'd0);
    check("rst_axiod", {14'd0, bus.axiod}, 16'd0);
    check("rst_level", {11'd0, bus.level}, 16'd0);
    check("rst_ucnt", bus.underflow_count, 16'd0);
    rst = 1'b1;
    tick();

    // Two bytes, LS dibit first.
    push(8'hB4);
    push(8'h1E);
    check("t1_level", {11'd0, bus.level}, 16'd2);
    seq8 = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b10, 2'b11, 2'b01, 2'b00};
    bus.stall = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t1_dibit%0d", i), {14'd0, bus.axiod}, {14'd0, seq8[i]});
      check($sformatf("t1_axiov%0d", i), {15'd0, bus.axiov}, 16'd1);
      tick();
    end
    bus.stall = 1'b1;
    check("t1_axiov_end", {15'd0, bus.axiov}, 16'd0);
    check("t1_ucnt", bus.underflow_count, 16'd0);

    // Five bytes held by stall, then drained.
    bytes5 = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A};
    for (int i = 0; i < 5; i++) push(bytes5[i]);
    for (int i = 0; i < 10; i++) begin
      check("t2_frozen", {14'd0, bus.axiod}, 16'd2);
      tick();
    end
    check("t2_level", {11'd0, bus.level}, 16'd5);
    bus.stall = 1'b0;
    for (int i = 0; i < 5; i++) read_byte($sformatf("t2_byte%0d", i), bytes5[i]);
    bus.stall = 1'b1;

    // Starvation: seven fill dibits consumed.
    bus.stall = 1'b0;
    for (int i = 0; i < 7; i++) begin
      check("t3_fill", {14'd0, bus.axiod}, 16'd0);
      tick();
    end
    bus.stall = 1'b1;
    check("t3_axiov", {15'd0, bus.axiov}, 16'd0);
    check("t3_ucnt", bus.underflow_count, 16'd7);
    push(8'hFF);
    bus.stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("t3_ff", {14'd0, bus.axiod}, 16'd3);
      tick();
    end
    bus.stall = 1'b1;
    check("t3_ucnt_after", bus.underflow_count, 16'd7);

    // Full FIFO, ignored push, one pop, wrapped push, readback.
    for (int i = 0; i < 16; i++) push(8'h40 + 8'(i));
    check("t4_full_rdy", {15'd0, bus.axiir}, 16'd0);
    check("t4_full_level", {11'd0, bus.level}, 16'd16);
    push(8'hEE);
    check("t4_ignored", {11'd0, bus.level}, 16'd16);
    bus.stall = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("t4_rdy_prepop", {15'd0, bus.axiir}, 16'd0);
    tick();
    bus.stall = 1'b1;
    check("t4_rdy_postpop", {15'd0, bus.axiir}, 16'd1);
    check("t4_level_postpop", {11'd0, bus.level}, 16'd15);
    push(8'h5A);
    check("t4_refull", {11'd0, bus.level}, 16'd16);
    bus.stall = 1'b0;
    for (int i = 1; i < 16; i++) read_byte($sformatf("t4_rb%0d", i), 8'h40 + 8'(i));
    read_byte("t4_rb_wrap", 8'h5A);
    bus.stall = 1'b1;

    // Stall at idx 2, long hold, resume.
    push(8'hB4);
    push(8'h3C);
    bus.stall = 1'b0;
    tick();
    tick();
    bus.stall = 1'b1;
    for (int i = 0; i < 48; i++) tick();
    check("t5_hold_dibit", {14'd0, bus.axiod}, 16'd3);
    check("t5_hold_level", {11'd0, bus.level}, 16'd2);
    bus.stall = 1'b0;
    check("t5_res2", {14'd0, bus.axiod}, 16'd3);
    tick();
    check("t5_res3", {14'd0, bus.axiod}, 16'd2);
    tick();
    read_byte("t5_next", 8'h3C);
    bus.stall = 1'b1;

    // Flush drops the concurrent push and keeps the underflow count.
    push(8'h11);
    push(8'h22);
    bus.flush = 1'b1;
    push(8'h77);
    bus.flush = 1'b0;
    check("fl_level", {11'd0, bus.level}, 16'd0);
    check("fl_axiov", {15'd0, bus.axiov}, 16'd0);
    check("fl_ucnt", bus.underflow_count, 16'd7);

    // Async reset mid-byte with three bytes stored.
    push(8'hC6);
    push(8'h01);
    push(8'h02);
    bus.stall = 1'b0;
    tick();
    bus.stall = 1'b1;
    check("t6_prelevel", {11'd0, bus.level}, 16'd3);
    #2;
    rst = 1'b0;
    #1;
    check("t6_axiir", {15'd0, bus.axiir}, 16'd1);
    check("t6_axiov", {15'd0, bus.axiov}, 16'd0);
    check("t6_axiod", {14'd0, bus.axiod}, 16'd0);
    check("t6_level", {11'd0, bus.level}, 16'd0);
    check("t6_ucnt", bus.underflow_count, 16'd0);
    #1;
    rst = 1'b1;
    tick();
    push(8'h2D);
    check("t6_first", {14'd0, bus.axiod}, 16'd1);
    bus.stall = 1'b0;
    read_byte("t6_byte", 8'h2D);
    bus.stall = 1'b1;
    check("t6_end_level", {11'd0, bus.level}, 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/eth_payload_serializer.md
# eth_payload_serializer

Byte-to-dibit payload buffer that sits directly upstream of the Ethernet TX framer on FPGA1. Producer logic pushes payload bytes through a valid/ready handshake into an internal FIFO. The block presents them to the framer as an RMII-ordered dibit stream: least significant dibit first within each byte. It advances one dibit per cycle whenever the framer's `stall` is low, and substitutes fill dibits on starvation.

## Interface
- `DEPTH`, 16: FIFO depth in bytes; power of two, at least 4.
- `FILL_DIBIT`, 2'b00: dibit presented when the FIFO is empty.
- `clk`  in  1  system clock (50 MHz RMII clock domain).
- `rst`  in  1  asynchronous, active-low reset (block in reset while 0).
- `flush`  in  1  synchronous clear of FIFO contents and dibit index.
- `axiiv`  in  1  input byte valid.
- `axiid`  in  8  input byte.
- `axiir`  out  1  input ready; equals !full.
- `stall`  in  1  from framer; 0 = framer consumes `axiod` this cycle.
- `axiov`  out  1  equals !empty (dibit is real payload, not fill).
- `axiod`  out  2  current dibit to framer.
- `level`  out  $clog2(DEPTH)+1  bytes currently stored.
- `underflow_count`  out  16  saturating count of fill dibits consumed.

## Operation
- FIFO: circular buffer of `DEPTH` bytes with wr_ptr/rd_ptr of $clog2(DEPTH)+1 bits. Full when the low bits match and the MSBs differ; empty when the pointers are equal. Pointers wrap modulo 2·DEPTH.
- Push: on a clk edge with `axiiv && axiir && !flush`, write `axiid` at wr_ptr and increment wr_ptr.
- Dibit index `idx` (2 bits) selects within the head byte.
  - `axiod = head[2·idx+1 : 2·idx]` when not empty, else `FILL_DIBIT`.
  - Byte 0xB4 is emitted as 00, 01, 11, 10.
- Consume (edge with `stall==0 && !flush`):
  - not empty, idx<3: idx <= idx+1.
  - not empty, idx==3: idx <= 0 and pop (rd_ptr+1).
  - empty: idx unchanged, and `underflow_count` increments, saturating at 16'hFFFF.
- `stall` high: idx, rd_ptr and `axiod` hold. A byte partially sent when `stall` rises resumes at the same idx when the next frame's data phase begins.
- Simultaneous push and pop: both take effect and `level` is unchanged. There is no fall-through.
- `flush`: rd_ptr <= wr_ptr <= 0 and idx <= 0. Any push in the same cycle is dropped. `underflow_count` is not cleared.
- Reset (`rst`=0), asynchronous, at any time including mid-byte:
  - Pointers, idx and `underflow_count` are cleared to 0.
  - Outputs become `axiir`=1, `axiov`=0, `axiod`=`FILL_DIBIT`, `level`=0.
  - FIFO storage is not reset; its contents are don't-care.

## Timing
- All state changes on posedge `clk`; reset release is synchronous to the next edge.
- `axiod`/`axiov` are combinational from registered state only. They must be stable for the whole cycle because the framer drives `phy_txd` from `axiod` combinationally.
- `stall` is only sampled at the edge. There is no combinational path from `stall` to any output.
- Push-to-present latency:
  - A byte pushed into an empty FIFO at edge N is presented (`axiov`=1, idx=0) from edge N+1.
  - Its four dibits are consumed at the first four unstalled edges from N+1 on.
- `axiir` reflects registered full. A pop at edge N makes room visible after edge N, so a push can land at edge N+1.
- Throughput: the framer needs 20 dibits (5 bytes) per frame. A producer averaging one byte per 4 unstalled cycles never underflows.

## Test plan
- Reset, then push 0xB4 and 0x1E, `stall`=0 → `axiod` sequence 00,01,11,10,10,11,01,00; `axiov` falls after the 8th dibit; `underflow_count`=0.
- Push 5 bytes with `stall`=1 for 10 cycles → `axiod` frozen on byte0 dibit0 and `level`=5. Release `stall` → 20 dibits emitted in order.
- Drop `stall` with the FIFO empty for 7 cycles → `axiod`=00, `axiov`=0, `underflow_count`=7. Then push 0xFF → next dibits are 11 ×4.
- Fill 16 bytes (DEPTH=16) → `axiir`=0 and further pushes are ignored. Consume one byte → `axiir`=1 the cycle after the pop, and the next push is accepted with wraparound verified on readback.
- Raise `stall` at idx=2 of 0xB4, hold 48 cycles, lower it → dibits 11,10 resume, followed by the next byte.
- Assert `rst`=0 asynchronously mid-byte with `level`=3 → all outputs take reset values immediately, and after release the first push is output from idx 0.
